// File: rtl/mode_seq_pkg.sv
// Shared definitions for the mode sequencer: state codes, number of sensor
// front-ends, mode code constants and a one-hot request helper.
package mode_seq_pkg;

   localparam int NUM_MODES = 4;

   // FSM state codes
   localparam logic [2:0] ST_SETTLE   = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_REQ      = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK = 3'd3;
   localparam logic [2:0] ST_HOLD     = 3'd4;

   // Mode codes from the key decoder; codes 4..7 are invalid
   localparam logic [2:0] MODE_0 = 3'd0;
   localparam logic [2:0] MODE_1 = 3'd1;
   localparam logic [2:0] MODE_2 = 3'd2;
   localparam logic [2:0] MODE_3 = 3'd3;

   // One-hot request vector for the selected sensor
   function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] mode);
      logic [NUM_MODES-1:0] vec;
      vec       = {NUM_MODES{1'b0}};
      vec[mode] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Sensor / reporting bus of the mode sequencer.
//   master: sequencer side (drives req and the reporting outputs)
//   slave : sensor / display side (drives ack and sensor_data)
interface mode_sequencer_if
   import mode_seq_pkg::*;
#(
   parameter int DATA_W = 16
) ();
   logic [NUM_MODES-1:0] req;
   logic [NUM_MODES-1:0] ack;
   logic [DATA_W-1:0]    sensor_data;
   logic [DATA_W-1:0]    data_out;
   logic                 data_valid;
   logic [1:0]           mode_out;
   logic                 invalid_mode;
   logic                 timeout_pulse;
   logic                 timeout_err;

   modport master (
      output req, data_out, data_valid, mode_out, invalid_mode, timeout_pulse, timeout_err,
      input  ack, sensor_data
   );

   modport slave (
      input  req, data_out, data_valid, mode_out, invalid_mode, timeout_pulse, timeout_err,
      output ack, sensor_data
   );
endinterface

// File: rtl/mode_sequencer_sync.sv
// mode_sync: brings the asynchronous 3-bit mode code into the clk domain
// through two flops, keeps a registered copy of the synchronised value and
// flags a change for one cycle whenever the two differ.
//   clk, reset  : clock, asynchronous active-low reset
//   code_i      : raw mode code (asynchronous)
//   code_o      : synchronised mode code
//   changed_o   : synchronised code differs from its registered copy
module mode_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] code_i,
   output logic [2:0] code_o,
   output logic       changed_o
);
   logic [2:0] meta_q;
   logic [2:0] sync_q;
   logic [2:0] copy_q;

   // Two-flop synchroniser followed by the comparison copy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 3'd0;
         sync_q <= 3'd0;
         copy_q <= 3'd0;
      end else begin
         meta_q <= code_i;
         sync_q <= meta_q;
         copy_q <= sync_q;
      end
   end

   assign code_o    = sync_q;
   assign changed_o = (sync_q != copy_q);
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: selects one of four sensor front-ends from the synchronised
// mode code and runs a periodic request/acknowledge transaction with it,
// presenting each captured reading with a one-cycle valid strobe.
//   clk, reset : clock, asynchronous active-low reset
//   enable     : 3-bit mode code from the key decoder (asynchronous)
//   bus        : mode_sequencer_if.master (req/ack/sensor_data, data_out,
//                data_valid, mode_out, invalid_mode, timeout_pulse, timeout_err)
// Optional feature: define MODE_SEQ_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES; otherwise WAIT_ACK waits indefinitely and the timeout
// outputs are tied low.
module mode_sequencer
   import mode_seq_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int SETTLE_CYCLES  = 16,
   parameter int SAMPLE_PERIOD  = 50000,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] enable,
   mode_sequencer_if.master bus
);
   // One saturating counter serves settle, hold and timeout; it is sized for the largest
   localparam int MAX_SH = (SETTLE_CYCLES > SAMPLE_PERIOD) ? SETTLE_CYCLES : SAMPLE_PERIOD;
   localparam int MAX_P  = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
   localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [NUM_MODES-1:0] REQ_NONE = {NUM_MODES{1'b0}};

   logic [2:0]           sync_code_s;
   logic                 changed_s;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_MODES-1:0] req_q, req_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 valid_q, valid_d;
   logic [1:0]           mode_q, mode_d;
   logic                 invalid_q;

   mode_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .code_i    (enable),
      .code_o    (sync_code_s),
      .changed_o (changed_s)
   );

`ifdef MODE_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic tpulse_q, tpulse_d;
   logic terr_q, terr_d;
`endif

   // Next-state logic; a synchronised mode change pre-empts every state
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
      req_d   = req_q;
      data_d  = data_q;
      valid_d = 1'b0;
      mode_d  = mode_q;
`ifdef MODE_SEQ_TIMEOUT_EN
      tpulse_d = 1'b0;
      terr_d   = terr_q;
`endif
      if (changed_s) begin
         // No capture here even if ack is present in this cycle
         req_d   = REQ_NONE;
         mode_d  = sync_code_s[1:0];
         cnt_d   = CNT_ZERO;
         state_d = ST_SETTLE;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d   = CNT_ZERO;
                  state_d = sync_code_s[2] ? ST_IDLE : ST_REQ;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
            ST_IDLE: begin
               // Left only through a mode change
               req_d = REQ_NONE;
            end
            ST_REQ: begin
               req_d   = mode_onehot(mode_q);
               cnt_d   = CNT_ZERO;
               state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (bus.ack[mode_q]) begin
                  data_d  = bus.sensor_data;
                  valid_d = 1'b1;
                  req_d   = REQ_NONE;
                  cnt_d   = CNT_ZERO;
                  state_d = ST_HOLD;
`ifdef MODE_SEQ_TIMEOUT_EN
               end else if (cnt_q == TIMEOUT_LAST) begin
                  req_d    = REQ_NONE;
                  tpulse_d = 1'b1;
                  terr_d   = 1'b1;
                  cnt_d    = CNT_ZERO;
                  state_d  = ST_HOLD;
`endif
               end else begin
                  state_d = ST_WAIT_ACK;
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = CNT_ZERO;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               req_d   = REQ_NONE;
               cnt_d   = CNT_ZERO;
               state_d = ST_SETTLE;
            end
         endcase
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_SETTLE;
         cnt_q     <= CNT_ZERO;
         req_q     <= REQ_NONE;
         data_q    <= {DATA_W{1'b0}};
         valid_q   <= 1'b0;
         mode_q    <= 2'd0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         mode_q    <= mode_d;
         invalid_q <= sync_code_s[2];
      end
   end

`ifdef MODE_SEQ_TIMEOUT_EN
   // Timeout strobe and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tpulse_q <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         tpulse_q <= tpulse_d;
         terr_q   <= terr_d;
      end
   end

   assign bus.timeout_pulse = tpulse_q;
   assign bus.timeout_err   = terr_q;
`else
   assign bus.timeout_pulse = 1'b0;
   assign bus.timeout_err   = 1'b0;
`endif

   assign bus.req          = req_q;
   assign bus.data_out     = data_q;
   assign bus.data_valid   = valid_q;
   assign bus.mode_out     = mode_q;
   assign bus.invalid_mode = invalid_q;
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Consumer of the 3-bit mode code produced by the front-panel key decoder. It synchronises the mode code into the system clock domain and selects one of four sensor front-ends. It then runs a periodic request/acknowledge transaction with the selected sensor and presents the captured reading, with a one-cycle valid strobe, to the display and reporting path.

## Interface
- `DATA_W`, 16: sensor reading width.
- `SETTLE_CYCLES`, 16: quiet cycles after reset or a mode change, before the first request.
- `SAMPLE_PERIOD`, 50000: cycles between the end of one transaction and the next request.
- `TIMEOUT_CYCLES`, 1000: maximum cycles a request waits for acknowledge (only with the timeout macro).
- `clk`  in  1  system clock.
- `reset`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  3  mode code from the key decoder. Asynchronous to `clk`. Valid codes are 0..3.
- `req`  out  4  one-hot request to sensor `n`.
- `ack`  in  4  acknowledge from sensor `n`. Synchronous to `clk`.
- `sensor_data`  in  DATA_W  reading. Valid in any cycle where the selected `ack` bit is high.
- `data_out`  out  DATA_W  last captured reading.
- `data_valid`  out  1  one-cycle strobe when `data_out` updates.
- `mode_out`  out  2  currently active mode.
- `invalid_mode`  out  1  high while the synchronised code is 4..7.
- `timeout_pulse`  out  1  one-cycle strobe on an abandoned request.
- `timeout_err`  out  1  sticky timeout flag. Cleared only by reset.

## Operation
- `enable` passes through a 2-flop synchroniser, then a registered copy. A "change" is the synchronised value differing from the registered copy.
- Reset values: `req`=0, `data_out`=0, `data_valid`=0, `mode_out`=0, `invalid_mode`=0, `timeout_pulse`=0, `timeout_err`=0. The FSM starts in SETTLE.
- **SETTLE:** counts `SETTLE_CYCLES`, then goes to REQ. If the code is 4..7, it goes to IDLE instead.
- **IDLE:** no requests are issued. `invalid_mode`=1. A change to a code of 0..3 goes to SETTLE.
- **REQ:** asserts `req[mode_out]` and moves to WAIT_ACK on the same edge.
- **WAIT_ACK:** `req` is held.
  - If `ack[mode_out]`=1: capture `sensor_data` into `data_out`, pulse `data_valid`, drop `req`, go to HOLD.
  - Timeout: the counter reaches `TIMEOUT_CYCLES`. Drop `req`, pulse `timeout_pulse`, set `timeout_err`, go to HOLD.
- **HOLD:** counts `SAMPLE_PERIOD` cycles, then goes to REQ.
- A change in any state overrides everything else:
  - drop `req`, load `mode_out` with the new code's low 2 bits, clear counters, go to SETTLE;
  - no capture occurs, even if ack arrives in the same cycle.
- `ack` bits other than `ack[mode_out]` are ignored in all states.
- `ack` outside WAIT_ACK is ignored.
- All counters are sized with `$clog2` of their parameter and saturate, never wrap.

## Timing
- `req` asserts on the first edge after REQ is entered. The minimum request width is 1 cycle.
- Capture: `data_out` and `data_valid` update on the edge that samples `ack[mode_out]`=1. `req` is low on that same edge.
- After reset release, the first `req` rises `SETTLE_CYCLES`+1 cycles later.
- Period from one `data_valid` to the next request edge: `SAMPLE_PERIOD`+1 cycles.
- Mode change: from the edge at which `enable` is first stable, `req` drops within 3 cycles and `mode_out` updates in the same cycle.
- Reset asserted mid-transaction: `req` and all outputs clear immediately and asynchronously.

## Configuration
- `MODE_SEQ_TIMEOUT_EN` defined: the timeout counter, `timeout_pulse` and `timeout_err` are implemented as described above.
- Undefined: WAIT_ACK waits indefinitely, and only a mode change or reset exits it. `timeout_pulse` and `timeout_err` are tied to 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `mode_seq_pkg`:
  - state enum (SETTLE, IDLE, REQ, WAIT_ACK, HOLD);
  - `NUM_MODES`=4;
  - mode code constants.
- Sub-module `mode_sync`: 2-flop synchroniser plus registered copy. Outputs the synchronised code and a `changed` pulse.

## Test plan
Bench uses `SETTLE_CYCLES`=4, `SAMPLE_PERIOD`=10, `TIMEOUT_CYCLES`=8.
- Reset release with `enable`=0 and sensor 0 acking 2 cycles after `req` with data 0x1234: `req`=0001 at cycle 5, `data_out`=0x1234, one `data_valid` pulse, next `req` 11 cycles after capture.
- `enable` changed 0→2 during WAIT_ACK: `req` drops within 3 cycles, `mode_out`=2, no `data_valid`, `req`=0100 after the settle period.
- Sensor 1 never acks, macro defined: `req` held 8 cycles, then `timeout_pulse` for 1 cycle, `timeout_err`=1 and held; the next request follows 10 cycles later.
- `enable`=5: `invalid_mode`=1 and `req` stays 0000. Returning to 3 gives `req`=1000 after the settle period.
- `ack`=0010 while `mode_out`=0: ignored, no capture. `ack`=0001 in the same cycle as a mode change: no capture.
- Reset asserted while `req`=0001: `req`, `data_out` and `mode_out` are 0 immediately, with no clock edge.
